// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes and FSM states.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_MUL    = 3'b101;
    localparam logic [2:0] OP_PASS_A = 3'b110;
    localparam logic [2:0] OP_ILL    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seq_alu_alu_comb.sv
// Combinational WIDTH-bit ADD/SUB/logic unit with carry and signed overflow.
// MUL and the illegal code produce all-zero outputs here.
module alu_comb
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_res,
    output logic             o_c,
    output logic             o_v
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    // SUB is A + ~B + 1, so carry-out means "no borrow"
    assign w_sub   = (i_op == OP_SUB);
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    // Same-sign operands into the adder with a differing result sign covers both ADD and SUB
    assign w_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    // Select the result for the requested op; flags only meaningful for ADD/SUB
    always_comb begin
        o_res = '0;
        o_c   = 1'b0;
        o_v   = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB: begin
                o_res = w_sum[WIDTH-1:0];
                o_c   = w_sum[WIDTH];
                o_v   = w_ovf;
            end
            OP_AND:    o_res = i_a & i_b;
            OP_OR:     o_res = i_a | i_b;
            OP_XOR:    o_res = i_a ^ i_b;
            OP_PASS_A: o_res = i_a;
            default: begin
                o_res = '0;
                o_c   = 1'b0;
                o_v   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle
// ops complete at the accept edge; MUL runs a WIDTH-cycle shift-add loop
// that reuses the combinational adder of alu_comb.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp_A,
    input  logic [WIDTH-1:0] inp_B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_err
);

    state_t               r_state;
    logic [WIDTH-1:0]     r_out;
    logic [WIDTH-1:0]     r_out_hi;
    logic                 r_c;
    logic                 r_v;
    logic                 r_z;
    logic                 r_err;
    logic                 r_valid;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_busy;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_alu_a;
    logic [WIDTH-1:0]     w_alu_b;
    logic [2:0]           w_alu_op;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_c;
    logic                 w_alu_v;
    logic [WIDTH:0]       w_hi_sum;
    logic [2*WIDTH:0]     w_acc_add;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_busy     = (r_state == ST_BUSY);
    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // While BUSY the adder serves the multiply: upper accumulator half + latched A
    assign w_alu_a  = w_busy ? r_acc[2*WIDTH-1:WIDTH] : inp_A;
    assign w_alu_b  = w_busy ? r_mul_a : inp_B;
    assign w_alu_op = w_busy ? OP_ADD : op;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a   (w_alu_a),
        .i_b   (w_alu_b),
        .i_op  (w_alu_op),
        .o_res (w_alu_res),
        .o_c   (w_alu_c),
        .o_v   (w_alu_v)
    );

    // Pre-shift accumulator keeps the adder carry in its top bit, then shifts right
    assign w_hi_sum   = r_mul_b[0] ? {w_alu_c, w_alu_res} : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_acc_add  = {w_hi_sum, r_acc[WIDTH-1:0]};
    assign w_acc_next = w_acc_add[2*WIDTH:1];

    // Handshake FSM, multiply iteration and registered result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_out    <= '0;
            r_out_hi <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_z      <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (op == OP_MUL) begin
                            r_mul_a <= inp_A;
                            r_mul_b <= inp_B;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_valid <= 1'b0;
                            r_state <= ST_BUSY;
                        end else begin
                            r_out    <= w_alu_res;
                            r_out_hi <= '0;
                            r_c      <= w_alu_c;
                            r_v      <= w_alu_v;
                            r_z      <= (w_alu_res == '0);
                            r_err    <= (op == OP_ILL);
                            r_valid  <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_mul_b <= r_mul_b >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_out    <= w_acc_next[WIDTH-1:0];
                        r_out_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_c      <= 1'b0;
                        r_v      <= 1'b0;
                        r_z      <= (w_acc_next == '0);
                        r_err    <= 1'b0;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out       = r_out;
    assign out_hi    = r_out_hi;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign flag_z    = r_z;
    assign flag_err  = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard testbench for seq_alu (WIDTH=5).
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] inp_A = '0;
    logic [W-1:0] inp_B = '0;
    logic [2:0]   op = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         flag_c;
    logic         flag_v;
    logic         flag_z;
    logic         flag_err;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         c;
        logic         v;
        logic         z;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp_A     (inp_A),
        .inp_B     (inp_B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_err  (flag_err)
    );

    // Reference model built from integer arithmetic
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ua, ub, sa, sb_, r, rs;
        e  = '0;
        ua = int'(a);
        ub = int'(b);
        sa = ua - (a[W-1] ? (1 << W) : 0);
        sb_ = ub - (b[W-1] ? (1 << W) : 0);
        case (o)
            OP_ADD: begin
                r = ua + ub; e.out = r[W-1:0]; e.c = (r >= (1 << W));
                rs = sa + sb_; e.v = (rs > (1 << (W-1)) - 1) || (rs < -(1 << (W-1)));
            end
            OP_SUB: begin
                r = ua - ub; e.out = r[W-1:0]; e.c = (ua >= ub);
                rs = sa - sb_; e.v = (rs > (1 << (W-1)) - 1) || (rs < -(1 << (W-1)));
            end
            OP_AND:    e.out = a & b;
            OP_OR:     e.out = a | b;
            OP_XOR:    e.out = a ^ b;
            OP_PASS_A: e.out = a;
            OP_MUL: begin
                r = ua * ub; e.out = r[W-1:0]; e.hi = r[2*W-1:W];
            end
            default:   e.err = 1'b1;
        endcase
        e.z = ({e.hi, e.out} == '0);
        return e;
    endfunction

    // Scoreboard: compare every result the consumer takes
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got out=%0d hi=%0d with no result pending", out, out_hi);
            end else begin
                e = sb.pop_front();
                if ({out, out_hi, flag_c, flag_v, flag_z, flag_err} !== {e.out, e.hi, e.c, e.v, e.z, e.err}) begin
                    errors++;
                    $display("FAIL sb_result: got out=%0d hi=%0d c=%b v=%b z=%b err=%b, expected out=%0d hi=%0d c=%b v=%b z=%b err=%b",
                             out, out_hi, flag_c, flag_v, flag_z, flag_err, e.out, e.hi, e.c, e.v, e.z, e.err);
                end
            end
        end
    end

    // Present one op and hold it until accepted; returns 1ns after the accept edge
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit done = 0;
        in_valid = 1'b1; op = o; inp_A = a; inp_B = b;
        for (int unsigned k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(o, a, b));
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL issue_timeout: op=%0d never accepted, required acceptance within 50 cycles", o);
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int unsigned k = 0; k < 64 && !done; k++) begin
            if (sb.size() == 0 && !out_valid) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({out_valid, out, out_hi} !== '0) begin
            errors++;
            $display("FAIL reset_data: got valid=%b out=%0d hi=%0d, required all 0", out_valid, out, out_hi);
        end
        checks++;
        if ({flag_c, flag_v, flag_z, flag_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000", {flag_c, flag_v, flag_z, flag_err});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(OP_ADD, 5'd31, 5'd1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd0 || flag_c !== 1'b1 || flag_z !== 1'b1 || flag_v !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap: got valid=%b out=%0d c=%b z=%b v=%b, required 1 0 1 1 0",
                     out_valid, out, flag_c, flag_z, flag_v);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out !== 5'd0) begin
            errors++;
            $display("FAIL add_release: got valid=%b out=%0d, required valid=0 out=0 held", out_valid, out);
        end
        @(posedge clk); #1;
        for (int unsigned i = 0; i < 10; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 5));
            if (o == OP_MUL) o = OP_PASS_A;
            issue(o, W'($urandom_range(0, 31)), W'($urandom_range(0, 31)));
            drain();
        end
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        issue(OP_SUB, 5'd3, 5'd5);
        @(negedge clk);
        checks++;
        if (out !== 5'd30 || flag_c !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: got out=%0d c=%b, required out=30 c=0", out, flag_c);
        end
        @(posedge clk); #1;
        issue(OP_SUB, 5'b01111, 5'b10000);
        @(negedge clk);
        checks++;
        if (flag_v !== 1'b1) begin
            errors++;
            $display("FAIL sub_overflow: got v=%b, required 1", flag_v);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_mul();
        out_ready = 1'b1;
        issue(OP_MUL, 5'd31, 5'd31);
        in_valid = 1'b1; op = OP_ADD; inp_A = 5'd1; inp_B = 5'd1;
        for (int unsigned k = 0; k < 5; k++) begin
            if (k == 3) in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy[%0d]: got valid=%b in_ready=%b, required 0 0", k, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd1 || out_hi !== 5'd30) begin
            errors++;
            $display("FAIL mul_31x31: got valid=%b hi=%0d out=%0d, required 1 30 1", out_valid, out_hi, out);
        end
        @(posedge clk); #1;
        drain();
        for (int unsigned i = 0; i < 5; i++) begin
            issue(OP_MUL, W'($urandom_range(0, 31)), W'($urandom_range(0, 31)));
            drain();
        end
        issue(OP_MUL, 5'd0, 5'd23);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops  [3] = '{OP_AND, OP_OR, OP_XOR};
        logic [W-1:0] want [3] = '{5'b00101, 5'b11111, 5'b11010};
        out_ready = 1'b1;
        in_valid = 1'b1; inp_A = 5'b10101; inp_B = 5'b01111;
        for (int unsigned i = 0; i < 3; i++) begin
            op = ops[i];
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got in_ready=%b, required 1", i, in_ready);
            end else begin
                sb.push_back(model(ops[i], inp_A, inp_B));
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out !== want[i-1]) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got valid=%b out=%b, required 1 %b", i - 1, out_valid, out, want[i-1]);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== want[2]) begin
            errors++;
            $display("FAIL b2b_result[2]: got valid=%b out=%b, required 1 %b", out_valid, out, want[2]);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(OP_ADD, 5'd2, 5'd3);
        in_valid = 1'b1; op = OP_SUB; inp_A = 5'd7; inp_B = 5'd1;
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out !== 5'd5 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b out=%0d in_ready=%b, required 1 5 0",
                         k, out_valid, out, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b, required 1", in_ready);
        end else begin
            sb.push_back(model(OP_SUB, 5'd7, 5'd1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out !== 5'd6) begin
            errors++;
            $display("FAIL bp_next: got valid=%b out=%0d, required 1 6", out_valid, out);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        issue(OP_MUL, 5'd13, 5'd7);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out !== 5'd0 || out_hi !== 5'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_reset: got valid=%b out=%0d hi=%0d in_ready=%b, required 0 0 0 1",
                     out_valid, out, out_hi, in_ready);
        end
        @(posedge clk); #1;
        issue(OP_ILL, 5'd5, 5'd9);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || flag_err !== 1'b1 || out !== 5'd0 || flag_z !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op: got valid=%b err=%b out=%0d z=%b, required 1 1 0 1",
                     out_valid, flag_err, out, flag_z);
        end
        @(posedge clk); #1;
        drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mul();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000ns");
        $fatal(1);
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 5-bit bit-slice ALU.
- Input and output sides each use a valid/ready handshake.
- Single-cycle ops: add, sub, and, or, xor, pass. Multi-cycle op: shift-add multiply.
- Produces result, upper product half and status flags. Sits between the operand register file and the writeback/display logic.

Parameters:
- WIDTH, 5, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op are valid
- in_ready  output  1  block can accept a new operation
- inp_A  input  WIDTH  operand A (unsigned; signed view for overflow)
- inp_B  input  WIDTH  operand B
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 PASS_A, 111 illegal
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes the result
- out  output  WIDTH  result (low half for MUL)
- out_hi  output  WIDTH  upper product half for MUL, 0 otherwise
- flag_c  output  1  ADD carry-out / SUB no-borrow; 0 for other ops
- flag_v  output  1  signed overflow for ADD/SUB; 0 for other ops
- flag_z  output  1  {out_hi,out} == 0
- flag_err  output  1  illegal op

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; out, out_hi, all flags and out_valid = 0. rst overrides everything, including an in-progress MUL, which is discarded with no result.
- States:
  - IDLE: in_ready=1.
  - BUSY: MUL iterating; in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept: an operation is accepted when in_valid && in_ready at a clock edge.
- Single-cycle op accepted at edge N: result, flags and out_valid=1 are registered at edge N, visible in cycle N+1; state goes to DONE.
- MUL accepted at edge N:
  - Latch A, B; clear the accumulator; cnt=0; go to BUSY.
  - One iteration per cycle: if multiplier LSB is 1, add A to the upper accumulator half; shift right with carry.
  - After WIDTH iterations, enter DONE. out_valid rises WIDTH cycles after the accept edge.
  - Full 2*WIDTH-bit product: low half on out, high half on out_hi. flag_c=flag_v=0.
- SUB: A + ~B + 1. flag_c=1 when A >= B unsigned.
- flag_v: ADD sets it when A and B have the same sign and the result sign differs. SUB sets it when A and B have different signs and the result sign differs from A.
- Illegal op: accepted like a single-cycle op; out=out_hi=0, flag_err=1, flag_z=1.
- DONE && out_ready && !in_valid → IDLE, out_valid=0. Data registers keep their last value.
- DONE && out_ready && in_valid (back-to-back):
  - Single-cycle op: new result loaded, out_valid stays 1, one result per cycle.
  - MUL: go to BUSY, out_valid=0.
- DONE && !out_ready: outputs held stable; in_ready=0 (no overwrite).
- in_valid during BUSY: ignored (in_ready=0). The producer must hold its request.
- Wrap-around: ADD/SUB results are modulo 2^WIDTH; the carry appears only in flag_c.
- Internal widths:
  - Adder WIDTH+1 bits.
  - Accumulator 2*WIDTH+1 bits (the extra bit holds the carry before the shift).
  - Counter CNT_W bits.

Decomposition:
- Package seq_alu_pkg holds:
  - op encodings as localparams: OP_ADD … OP_ILL.
  - state encodings: ST_IDLE, ST_BUSY, ST_DONE.
- One sub-module, alu_comb: parametrised combinational WIDTH-bit ADD/SUB/logic unit producing result, c and v. seq_alu instantiates it and reuses its adder for the multiply iterations.
- FSM, counter and handshake stay in seq_alu.

Test Plan:
- WIDTH=5, ADD 5'd31+5'd1 → out=0, flag_c=1, flag_z=1, flag_v=0, out_valid 1 cycle after accept.
- WIDTH=5, SUB 5'd3-5'd5 → out=5'd30, flag_c=0. SUB 5'b01111-5'b10000 → flag_v=1.
- WIDTH=5, MUL 31*31 → {out_hi,out}=10'd961 (out_hi=30, out=1), out_valid exactly 5 cycles after accept, in_ready=0 throughout BUSY.
- Back-to-back: out_ready=1, in_valid=1 for AND, OR, XOR with A=5'b10101, B=5'b01111 → results 00101, 11111, 11010 on consecutive cycles.
- Backpressure: out_ready=0 for 4 cycles after ADD 2+3 → out=5 held, in_ready=0, new in_valid not accepted. Release → accepted next edge.
- Reset mid-MUL at iteration 2 → next cycle out_valid=0, out=0, state IDLE, in_ready=1. Op 111 → flag_err=1, out=0.
